// File: rtl/pe_sequencer.sv
// Control FSM stepping one PE through clear / fetch / drain / [bias] / write / done.
// Build option: define PE_SEQ_BIAS_EN to include the BIAS state (mux_select=10).
module pe_sequencer #(
  parameter int CNT_W = 8,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_inputs,
  input  logic [ID_W-1:0]  neuron_id,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] rd_addr,
  output logic             read_enable,
  output logic [1:0]       mux_select,
  output logic [ID_W-1:0]  demux_select,
  output logic             write_enable
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
`ifdef PE_SEQ_BIAS_EN
    BIAS,
`endif
    WRITE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] addr_d;
  logic [ID_W-1:0]  id_d;
  logic             acc_en, acc_d;
  logic             busy_d, done_d, err_d, re_d, we_d;
  logic [1:0]       mux_d;

  // Next state plus next value of every registered output (Moore, fully registered)
  always_comb begin
    state_d = state;
    n_d     = n_q;
    id_d    = demux_select;
    addr_d  = rd_addr;
    err_d   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (num_inputs != '0) begin
            state_d = CLEAR;
            n_d     = num_inputs;
            id_d    = neuron_id;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = FETCH;
        addr_d  = '0;
      end
      FETCH: begin
        // Exit on the last index so N = 2^CNT_W-1 never needs the counter to wrap
        if (rd_addr == n_q - ONE) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = rd_addr + ONE;
        end
      end
`ifdef PE_SEQ_BIAS_EN
      DRAIN:   state_d = BIAS;
      BIAS:    state_d = WRITE;
`else
      DRAIN:   state_d = WRITE;
`endif
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (abort && state != IDLE) begin
      state_d = IDLE;
      addr_d  = '0;
      err_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    re_d   = (state_d == FETCH);
    we_d   = (state_d == WRITE);
    // Memory returns data one cycle after the read strobe
    acc_d  = read_enable && (state_d != IDLE);

    mux_d = 2'b11;
    case (state_d)
      CLEAR: mux_d = 2'b00;
      FETCH: mux_d = acc_d ? 2'b01 : 2'b11;
      DRAIN: mux_d = 2'b01;
`ifdef PE_SEQ_BIAS_EN
      BIAS:  mux_d = 2'b10;
`endif
      default: mux_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      n_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rd_addr      <= '0;
      read_enable  <= 1'b0;
      mux_select   <= 2'b11;
      demux_select <= '0;
      write_enable <= 1'b0;
      acc_en       <= 1'b0;
    end else begin
      state        <= state_d;
      n_q          <= n_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      rd_addr      <= addr_d;
      read_enable  <= re_d;
      mux_select   <= mux_d;
      demux_select <= id_d;
      write_enable <= we_d;
      acc_en       <= acc_d;
    end
  end

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Control FSM that sequences one processing element (PE) through a full neuron evaluation: clear accumulator, stream N input/weight pairs, optionally add bias, write the result to the selected output slot. Sits between the layer-level scheduler (start/done handshake) and the PE's control pins (mux_select, demux_select, read_enable, write_enable). It also generates the shared input/weight memory read address. Purely control; no datapath arithmetic.

## Interface
Parameters:
- CNT_W, 8, width of input count and read address (N ≤ 2^CNT_W−1)
- ID_W, 4, width of output slot index / demux_select

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request one neuron evaluation (level-sampled)
- num_inputs  in  CNT_W  N, inputs to accumulate; sampled with start
- neuron_id  in  ID_W  destination slot; sampled with start
- abort  in  1  synchronous cancel of the current evaluation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the result write
- err  out  1  one-cycle pulse: start rejected (num_inputs==0)
- rd_addr  out  CNT_W  input/weight memory index
- read_enable  out  1  memory read strobe
- mux_select  out  2  PE accumulator op: 00 clear, 01 accumulate, 10 add bias, 11 hold
- demux_select  out  ID_W  PE output routing; latched neuron_id
- write_enable  out  1  PE result write strobe

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, BIAS (macro-dependent), WRITE, DONE.
- IDLE: start=1, num_inputs≠0 → latch N, neuron_id → CLEAR. start=1, num_inputs=0 → err pulse next cycle, stay IDLE.
- CLEAR (1 cycle): mux_select=00.
- FETCH (N cycles): read_enable=1, rd_addr=0..N−1 incrementing. Memory latency is 1 cycle, so acc_en is a 1-cycle-delayed copy of read_enable; mux_select=01 whenever acc_en=1.
- DRAIN (1 cycle): final accumulate (mux_select=01); read_enable=0.
- BIAS (1 cycle): mux_select=10.
- WRITE (1 cycle): write_enable=1; demux_select holds the latched id throughout the evaluation.
- DONE (1 cycle): done=1. If start is valid here, accept it → CLEAR (back-to-back, no IDLE cycle). Otherwise → IDLE.
- start while busy (other than DONE) is ignored; inputs are not re-latched.
- abort=1 in any non-IDLE state → IDLE next cycle, with no write_enable, no done, and mux_select=11. abort has priority over start in DONE.
- N counter is CNT_W bits. The FETCH→DRAIN exit is at rd_addr==N−1, so N=2^CNT_W−1 never wraps.
- Default outputs outside the listed states: read_enable=0, write_enable=0, mux_select=11.

## Timing
- Reset (reset=0, async) values: state IDLE, busy=0, done=0, err=0, rd_addr=0, read_enable=0, mux_select=11, demux_select=0, write_enable=0, acc_en=0.
- Reset deassertion mid-evaluation: the evaluation is lost and the block resumes in IDLE.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- start sampled at edge 0: CLEAR at cycle 1, FETCH cycles 2..N+1, DRAIN N+2, BIAS N+3, WRITE N+4, done N+5.
- Without bias: WRITE N+3, done N+4.
- busy rises at cycle 1 and falls the cycle after DONE, unless back-to-back start was accepted.

## Configuration
- PE_SEQ_BIAS_EN defined: BIAS state present; latency as above.
- PE_SEQ_BIAS_EN undefined: BIAS state removed, DRAIN → WRITE directly, and mux_select never takes 10.

## Test plan
- Bias enabled, start with N=3, id=5 → rd_addr 0,1,2 on cycles 2–4 and mux_select=01 on cycles 3–5. Then mux_select=10 at cycle 6, write_enable with demux_select=5 at cycle 7, done at cycle 8.
- Bias disabled, N=1, id=2 → read at cycle 2, accumulate at cycle 3, write at cycle 4, done at cycle 5. mux_select never 10.
- start with num_inputs=0 → err pulse at cycle 1; busy, read_enable and write_enable stay 0.
- abort at cycle 3 of an N=6 run → IDLE at cycle 4 with busy=0 and mux_select=11. No write_enable, no done.
- reset driven low mid-FETCH (asynchronously, between edges) → all outputs at reset values immediately. After release, a new start with N=2 completes with normal latency.
- Back-to-back and busy handling:
  - start held through an evaluation → second evaluation's CLEAR directly follows DONE, with no IDLE cycle.
  - start pulsed during FETCH → ignored; latched N/id unchanged.
